// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FIFO with an explicit occupancy counter,
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
// All outputs come from registers, so no input reaches an output combinationally.
module sync_fifo_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage is deliberately left out of reset so it can map onto RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  full_reg;
  logic                  empty_reg;
  logic                  almost_full_reg;
  logic                  almost_empty_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  logic                  wr_acc;
  logic                  rd_acc;

  // A full FIFO never accepts a write and an empty one never serves a read,
  // so there is no write-to-read bypass in either corner.
  assign wr_acc = wr_en & ~full_reg;
  assign rd_acc = rd_en & ~empty_reg;

  // Next occupancy; a simultaneous accepted read and write cancel out.
  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_acc) begin
      count_next = count_reg + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // Pointers, counter, registered read data, flags and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      data_out_reg     <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_reg   <= rd_ptr_reg + AW'(1);
        data_out_reg <= mem[rd_ptr_reg];
      end
      count_reg        <= count_next;
      // Flags look at the next count so they line up with the new occupancy.
      full_reg         <= (count_next == CW'(DEPTH));
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= CW'(AF_THRESH));
      almost_empty_reg <= (count_next <= CW'(AE_THRESH));
      overflow_reg     <= wr_en & full_reg;
      underflow_reg    <= rd_en & empty_reg;
    end
  end

  assign data_out     = data_out_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_core.sv
// tb_sync_fifo_core: table-driven directed vectors, hand-written corner
// sequences and a randomized run checked against a queue-based model.
module tb_sync_fifo_core;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty;
  logic [3:0]    count;
  logic          overflow, underflow;

  sync_fifo_core #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .AF_THRESH(AF),
    .AE_THRESH(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .data_in(data_in),
    .rd_en(rd_en),
    .data_out(data_out),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Directed vector: inputs plus the full expected output picture.
  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [3:0]    cnt;
    logic [5:0]    flags; // {full, empty, almost_full, almost_empty, overflow, underflow}
  } vec_t;

  vec_t tbl [21];

  int n_vec = 0;
  int n_err = 0;

  // Behavioural reference: a plain queue of stored words.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout;
  logic          m_ov;
  logic          m_un;

  function automatic vec_t mk(input logic wr, input logic rd, input logic [DW-1:0] din,
                              input logic [DW-1:0] dout, input logic [3:0] cnt,
                              input logic [5:0] flags);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.dout = dout; v.cnt = cnt; v.flags = flags;
    return v;
  endfunction

  function automatic logic [17:0] dut_out();
    return {data_out, count, full, empty, almost_full, almost_empty, overflow, underflow};
  endfunction

  function automatic logic [17:0] model_out();
    int n;
    n = q.size();
    return {m_dout, 4'(n), (n == DEPTH), (n == 0), (n >= AF), (n <= AE), m_ov, m_un};
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ov   = 1'b0;
    m_un   = 1'b0;
  endtask

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got dout/cnt/flags=%h required %h", name, act, exp);
    end else begin
      $display("[%0d] %s ok dout/cnt/flags=%h", n_vec, name, act);
    end
  endtask

  // Drive one cycle of stimulus, advance the model by the FIFO rules, sample #1 after the edge.
  task automatic apply(input logic wr, input logic [DW-1:0] din, input logic rd);
    bit was_full, was_empty;
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    m_ov = wr && was_full;
    m_un = rd && was_empty;
    if (rd && !was_empty) m_dout = q.pop_front();
    if (wr && !was_full)  q.push_back(din);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill 0x11..0x18, overflow with 0xAA, drain, then the empty corner cases.
    tbl[0]  = mk(1, 0, 8'h11, 8'h00, 4'd1, 6'b000100);
    tbl[1]  = mk(1, 0, 8'h12, 8'h00, 4'd2, 6'b000100);
    tbl[2]  = mk(1, 0, 8'h13, 8'h00, 4'd3, 6'b000000);
    tbl[3]  = mk(1, 0, 8'h14, 8'h00, 4'd4, 6'b000000);
    tbl[4]  = mk(1, 0, 8'h15, 8'h00, 4'd5, 6'b000000);
    tbl[5]  = mk(1, 0, 8'h16, 8'h00, 4'd6, 6'b001000);
    tbl[6]  = mk(1, 0, 8'h17, 8'h00, 4'd7, 6'b001000);
    tbl[7]  = mk(1, 0, 8'h18, 8'h00, 4'd8, 6'b101000);
    tbl[8]  = mk(1, 0, 8'hAA, 8'h00, 4'd8, 6'b101010);
    tbl[9]  = mk(0, 0, 8'h00, 8'h00, 4'd8, 6'b101000);
    tbl[10] = mk(0, 1, 8'h00, 8'h11, 4'd7, 6'b001000);
    tbl[11] = mk(0, 1, 8'h00, 8'h12, 4'd6, 6'b001000);
    tbl[12] = mk(0, 1, 8'h00, 8'h13, 4'd5, 6'b000000);
    tbl[13] = mk(0, 1, 8'h00, 8'h14, 4'd4, 6'b000000);
    tbl[14] = mk(0, 1, 8'h00, 8'h15, 4'd3, 6'b000000);
    tbl[15] = mk(0, 1, 8'h00, 8'h16, 4'd2, 6'b000100);
    tbl[16] = mk(0, 1, 8'h00, 8'h17, 4'd1, 6'b000100);
    tbl[17] = mk(0, 1, 8'h00, 8'h18, 4'd0, 6'b010100);
    tbl[18] = mk(0, 1, 8'h00, 8'h18, 4'd0, 6'b010101);
    tbl[19] = mk(1, 1, 8'h5C, 8'h18, 4'd1, 6'b000101);
    tbl[20] = mk(0, 1, 8'h00, 8'h5C, 4'd0, 6'b010100);

    // Reset and idle.
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset", dut_out(), {8'h00, 4'd0, 6'b010100});
    idle();
    chk("reset_idle", dut_out(), {8'h00, 4'd0, 6'b010100});

    // Directed table.
    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].wr, tbl[i].din, tbl[i].rd);
      chk($sformatf("tbl%0d", i), dut_out(), {tbl[i].dout, tbl[i].cnt, tbl[i].flags});
    end

    // Full with simultaneous read and write: read wins, write rejected.
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b1, 8'h21 + 8'(i), 1'b0);
      chk("fill2", dut_out(), model_out());
    end
    apply(1'b1, 8'hBB, 1'b1);
    chk("full_wr_rd", dut_out(), {8'h21, 4'd7, 6'b001010});
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b0, '0, 1'b1);
      chk("drain2", dut_out(), model_out());
    end

    // Wrap-around under continuous simultaneous traffic.
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 8'h40 + 8'(i), 1'b0);
      chk("preload", dut_out(), model_out());
    end
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 8'h50 + 8'(i), 1'b1);
      chk("wrap", dut_out(), model_out());
    end
    chk("wrap_last", dut_out(), {8'h5F, 4'd4, 6'b000000});
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, '0, 1'b1);
      chk("wrap_drain", dut_out(), model_out());
    end

    // Asynchronous reset between edges with five entries stored.
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 8'h70 + 8'(i), 1'b0);
    end
    apply(1'b0, '0, 1'b1);
    chk("pre_rst", dut_out(), {8'h70, 4'd4, 6'b000000});
    apply(1'b1, 8'h75, 1'b0);
    chk("pre_rst5", dut_out(), {8'h70, 4'd5, 6'b000000});
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst", dut_out(), {8'h00, 4'd0, 6'b010100});
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 8'h3C, 1'b0);
    chk("post_rst_wr", dut_out(), model_out());
    apply(1'b0, '0, 1'b1);
    chk("post_rst_rd", dut_out(), {8'h3C, 4'd0, 6'b010100});

    // Randomized traffic with shifting write/read bias to reach both ends.
    for (int i = 0; i < 400; i++) begin
      int p_wr;
      int p_rd;
      case (i / 100)
        0:       begin p_wr = 80; p_rd = 25; end
        1:       begin p_wr = 20; p_rd = 80; end
        default: begin p_wr = 50; p_rd = 50; end
      endcase
      apply(($urandom_range(99) < p_wr), 8'($urandom), ($urandom_range(99) < p_rd));
      chk($sformatf("rand%0d", i), dut_out(), model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
